// File: rtl/lc3_pipe_controller.sv
// lc3_pipe_controller: stage enables, memory/branch stalls and ALU bypass for LC-3.
// Optional feature macro BYPASS_EN: forward ALU results instead of stalling on hazards.
module lc3_pipe_controller (
  input  logic        clock,
  input  logic        reset,
  input  logic        complete_instr,
  input  logic        complete_data,
  input  logic [15:0] imem_dout,
  input  logic [15:0] ir,
  input  logic [15:0] ir_exec,
  input  logic [2:0]  nzp,
  output logic        enable_updatepc,
  output logic        enable_fetch,
  output logic        enable_decode,
  output logic        enable_execute,
  output logic        enable_writeback,
  output logic        br_taken,
  output logic [1:0]  mem_state,
  output logic        bypass_alu_1,
  output logic        bypass_alu_2
);

  typedef enum logic [2:0] {
    S_FILL,
    S_RUN,
    S_MEM,
    S_CTRL,
    S_HAZ
  } state_e;

  localparam logic [1:0] M_READ  = 2'd0;
  localparam logic [1:0] M_IND   = 2'd1;
  localparam logic [1:0] M_WRITE = 2'd2;
  localparam logic [1:0] M_IDLE  = 2'd3;

  localparam logic [3:0] OP_BR  = 4'b0000;
  localparam logic [3:0] OP_ADD = 4'b0001;
  localparam logic [3:0] OP_LD  = 4'b0010;
  localparam logic [3:0] OP_ST  = 4'b0011;
  localparam logic [3:0] OP_AND = 4'b0101;
  localparam logic [3:0] OP_LDR = 4'b0110;
  localparam logic [3:0] OP_STR = 4'b0111;
  localparam logic [3:0] OP_NOT = 4'b1001;
  localparam logic [3:0] OP_LDI = 4'b1010;
  localparam logic [3:0] OP_STI = 4'b1011;
  localparam logic [3:0] OP_JMP = 4'b1100;

  // Enable vector bit order: {wb, exe, dec, fetch, upc}
  localparam logic [4:0] EN_NONE = 5'b00000;
  localparam logic [4:0] EN_WB   = 5'b10000;
  localparam logic [4:0] EN_CTRL = 5'b11100;
  localparam logic [4:0] EN_RES  = 5'b11101;
  localparam logic [4:0] EN_ALL  = 5'b11111;

  function automatic logic is_alu(input logic [3:0] op);
    return op == OP_ADD || op == OP_AND || op == OP_NOT;
  endfunction

  function automatic logic is_mem(input logic [3:0] op);
    return op == OP_LD || op == OP_LDR || op == OP_LDI ||
           op == OP_ST || op == OP_STR || op == OP_STI;
  endfunction

  function automatic logic is_store(input logic [3:0] op);
    return op == OP_ST || op == OP_STR || op == OP_STI;
  endfunction

  function automatic logic is_ctl(input logic [3:0] op);
    return op == OP_BR || op == OP_JMP;
  endfunction

  function automatic logic [1:0] first_step(input logic [3:0] op);
    if (op == OP_LDI || op == OP_STI) return M_IND;
    if (op == OP_ST || op == OP_STR) return M_WRITE;
    return M_READ;
  endfunction

  state_e     state_q, state_d;
  logic [3:0] valid_q, valid_d;
  logic [1:0] cnt_q, cnt_d;
  logic       ctrl_q, ctrl_d;
  logic       jmp_q, jmp_d;
  logic       st_q, st_d;
  logic [1:0] mem_q, mem_d;
  logic [4:0] en_q, en_d;
  logic       br_q, br_d;
  logic       fresh_q;

  logic [3:0] op_f, op_d, op_e;
  logic       fetch_wait;
  logic       mem_hit, ctrl_hit;
  logic       cnt_done, br_cond;
  logic       mem_last, mem_wb;
  logic       alu_pair, raw1, raw2, haz;
  logic       unused_bits;

  assign op_f = imem_dout[15:12];
  assign op_d = ir[15:12];
  assign op_e = ir_exec[15:12];

  assign unused_bits = ^{imem_dout[11:0], ir[11:9],
                         ir[4:3], ir_exec[8:0]};

  assign fetch_wait = (state_q == S_RUN) & en_q[1] & ~complete_instr;

  assign enable_updatepc  = en_q[0] & ~fetch_wait;
  assign enable_fetch     = en_q[1] & ~fetch_wait;
  assign enable_decode    = en_q[2] & ~fetch_wait;
  assign enable_execute   = en_q[3];
  assign enable_writeback = en_q[4] | mem_wb;
  assign br_taken         = br_q;
  assign mem_state        = mem_q;

  assign mem_hit  = fresh_q & is_mem(op_e);
  assign ctrl_hit = is_ctl(op_f) & enable_fetch & complete_instr;
  assign cnt_done = (cnt_q == 2'd3);
  assign br_cond  = jmp_q | (|(ir_exec[11:9] & nzp));

  assign mem_last = complete_data &
                    (mem_q == M_READ || mem_q == M_WRITE);
  // Loads write back in the very cycle their final read completes.
  assign mem_wb   = (state_q == S_MEM) & ~st_q &
                    (mem_q == M_READ) & complete_data;

  assign alu_pair = en_q[3] & is_alu(op_e) & is_alu(op_d);
  assign raw1 = alu_pair & (ir[8:6] == ir_exec[11:9]);
  assign raw2 = alu_pair & (op_d == OP_ADD || op_d == OP_AND) &
                ~ir[5] & (ir[2:0] == ir_exec[11:9]);

`ifdef BYPASS_EN
  assign bypass_alu_1 = ~reset & raw1;
  assign bypass_alu_2 = ~reset & raw2;
  assign haz = 1'b0;
`else
  assign bypass_alu_1 = 1'b0;
  assign bypass_alu_2 = 1'b0;
  assign haz = raw1 | raw2;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_FILL;
      valid_q <= 4'b0000;
      cnt_q   <= 2'd0;
      ctrl_q  <= 1'b0;
      jmp_q   <= 1'b0;
      st_q    <= 1'b0;
      mem_q   <= M_IDLE;
      en_q    <= EN_NONE;
      br_q    <= 1'b0;
      fresh_q <= 1'b0;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      cnt_q   <= cnt_d;
      ctrl_q  <= ctrl_d;
      jmp_q   <= jmp_d;
      st_q    <= st_d;
      mem_q   <= mem_d;
      en_q    <= en_d;
      br_q    <= br_d;
      fresh_q <= en_q[3];
    end
  end

  always_comb begin
    state_d = state_q;
    valid_d = valid_q;
    cnt_d   = cnt_q;
    ctrl_d  = ctrl_q;
    jmp_d   = jmp_q;
    st_d    = st_q;
    mem_d   = mem_q;
    unique case (state_q)
      S_FILL: begin
        valid_d = {valid_q[2:0], 1'b1};
        if (valid_q[2:0] == 3'b111) state_d = S_RUN;
      end
      S_RUN: begin
        if (ctrl_hit) begin
          ctrl_d = 1'b1;
          cnt_d  = 2'd0;
          jmp_d  = (op_f == OP_JMP);
        end
        if (mem_hit) begin
          state_d = S_MEM;
          st_d    = is_store(op_e);
          mem_d   = first_step(op_e);
        end else if (ctrl_hit) begin
          state_d = S_CTRL;
        end else if (haz) begin
          state_d = S_HAZ;
        end
      end
      S_CTRL: begin
        if (mem_hit) begin
          state_d = S_MEM;
          st_d    = is_store(op_e);
          mem_d   = first_step(op_e);
        end else begin
          cnt_d = cnt_q + 2'd1;
          if (cnt_done) begin
            ctrl_d  = 1'b0;
            state_d = S_RUN;
          end
        end
      end
      S_MEM: begin
        if (complete_data) begin
          if (mem_q == M_IND) begin
            mem_d = st_q ? M_WRITE : M_READ;
          end else begin
            mem_d   = M_IDLE;
            state_d = ctrl_q ? S_CTRL : S_RUN;
          end
        end
      end
      S_HAZ: state_d = S_RUN;
      default: state_d = S_FILL;
    endcase
  end

  always_comb begin
    en_d = en_q;
    br_d = 1'b0;
    unique case (state_q)
      S_FILL: en_d = {valid_q[2:0], 1'b1, 1'b1};
      S_RUN: begin
        if (mem_hit)       en_d = EN_NONE;
        else if (ctrl_hit) en_d = EN_CTRL;
        else if (haz)      en_d = EN_WB;
        else               en_d = EN_ALL;
      end
      S_CTRL: begin
        if (mem_hit) begin
          en_d = EN_NONE;
        end else if (cnt_done) begin
          en_d = EN_RES;
          br_d = br_cond;
        end else begin
          en_d = EN_CTRL;
        end
      end
      S_MEM: begin
        if (mem_last) en_d = ctrl_q ? EN_CTRL : EN_ALL;
        else          en_d = EN_NONE;
      end
      S_HAZ: en_d = EN_ALL;
      default: en_d = EN_NONE;
    endcase
  end

endmodule
